// File: rtl/message_loader.sv
// Writer side of the rotating-message display: debounced write/clear buttons fill an
// 8 x 4-bit character memory. Define MESSAGE_LOADER_DEFAULT_MSG_EN to fill with a boot message.
module message_loader #(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw_data,
  input  logic       btn_write,
  input  logic       btn_clear,
  input  logic [2:0] rd_addr,
  output logic [3:0] rd_data,
  output logic [2:0] wr_ptr,
  output logic       msg_full,
  output logic       wr_strobe,
  output logic       busy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = '1;

`ifdef MESSAGE_LOADER_DEFAULT_MSG_EN
  localparam logic [3:0] FILL [8] = '{4'h1, 4'h4, 4'h3, 4'h5, 4'hA, 4'hB, 4'hC, 4'hD};
`else
  localparam logic [3:0] FILL [8] = '{default: 4'h0};
`endif

  // Button index 0 is write, 1 is clear.
  logic [1:0]               btn_raw;
  logic [1:0]               s1, s2, db, db_prev, press;
  logic [DEBOUNCE_BITS-1:0] cnt [2];

  state_t     state, next;
  logic [3:0] mem [8];
  logic [3:0] wr_hold;
  logic [2:0] sweep;
  logic [3:0] count;

  assign btn_raw   = {btn_clear, btn_write};
  assign press     = db & ~db_prev;
  assign msg_full  = (count == 4'd8);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1      <= '0;
      s2      <= '0;
      db      <= '0;
      db_prev <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1      <= btn_raw;
      s2      <= s1;
      db_prev <= db;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Presses seen outside IDLE are simply dropped; clear outranks write.
  always_comb begin
    next      = state;
    wr_strobe = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (press[1])      next = CLEAR;
        else if (press[0]) next = WRITE;
      end
      WRITE: begin
        wr_strobe = 1'b1;
        next      = IDLE;
      end
      CLEAR: begin
        busy = 1'b1;
        if (sweep == 3'd7) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      wr_hold <= '0;
      sweep   <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      for (int i = 0; i < 8; i++) mem[i] <= FILL[i];
    end else begin
      state   <= next;
      // Non-blocking read gives the pre-write word on an address collision.
      rd_data <= mem[rd_addr];
      case (state)
        IDLE: begin
          if (press[1])      sweep   <= '0;
          else if (press[0]) wr_hold <= sw_data;
        end
        WRITE: begin
          mem[wr_ptr] <= wr_hold;
          wr_ptr      <= wr_ptr + 3'd1;
          if (count != 4'd8) count <= count + 4'd1;
        end
        CLEAR: begin
          mem[sweep] <= FILL[sweep];
          sweep      <= sweep + 3'd1;
          if (sweep == 3'd7) begin
            wr_ptr <= '0;
            count  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_message_loader.sv
// Directed bench for message_loader with a short debounce window (DEBOUNCE_BITS = 2).
module tb_message_loader;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sw_data = '0;
  logic       btn_write = 1'b0;
  logic       btn_clear = 1'b0;
  logic [2:0] rd_addr = '0;
  logic [3:0] rd_data;
  logic [2:0] wr_ptr;
  logic       msg_full, wr_strobe, busy;
  logic [1:0] dbg_state;

  message_loader #(.DEBOUNCE_BITS(N)) dut (
    .clk(clk), .reset(reset), .sw_data(sw_data), .btn_write(btn_write),
    .btn_clear(btn_clear), .rd_addr(rd_addr), .rd_data(rd_data), .wr_ptr(wr_ptr),
    .msg_full(msg_full), .wr_strobe(wr_strobe), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

`ifdef MESSAGE_LOADER_DEFAULT_MSG_EN
  logic [3:0] exp_fill [8] = '{4'h1, 4'h4, 4'h3, 4'h5, 4'hA, 4'hB, 4'hC, 4'hD};
`else
  logic [3:0] exp_fill [8] = '{default: 4'h0};
`endif

  typedef struct {
    logic [2:0] addr;
    logic [3:0] data;
  } rd_vec_t;

  typedef struct {
    logic [3:0] val;
    logic [2:0] ptr;
    logic       full;
  } wr_vec_t;

  // Scoreboard state
  logic [3:0] exp_mem [8];
  logic [3:0] exp_q [$];
  logic [2:0] exp_ptr;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         strobe_cnt = 0;

  always @(negedge clk) if (wr_strobe) strobe_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_fill();
    for (int i = 0; i < 8; i++) exp_mem[i] = exp_fill[i];
    exp_ptr = '0;
  endtask

  task automatic read_all(input string tag);
    rd_vec_t tbl [8];
    for (int i = 0; i < 8; i++) begin
      tbl[i].addr = 3'(i);
      tbl[i].data = exp_mem[i];
      exp_q.push_back(exp_mem[i]);
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr = tbl[i].addr;
      tick();
      chk($sformatf("%s_rd%0d", tag, i), rd_data, exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    model_fill();
  endtask

  // Driver: press write until the strobe shows, then release and let it settle.
  task automatic do_write(input logic [3:0] val);
    int w = 0;
    sw_data   = val;
    btn_write = 1'b1;
    while (!wr_strobe && w < 20) begin
      tick();
      w++;
    end
    if (!wr_strobe) begin
      chk("write_timeout", 0, 1);
    end else begin
      exp_mem[exp_ptr] = val;
      exp_ptr = exp_ptr + 3'd1;
    end
    tick();
    btn_write = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    wr_vec_t wtbl [9];
    int s0;
    int w;

    // Reset state
    repeat (2) tick();
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_full", msg_full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_state", dbg_state, 0);
    reset = 1'b1;
    tick();
    model_fill();
    read_all("boot");

    // Single clean press: strobe at E+6, memory and pointer at E+7, collision read old word
    rd_addr   = 3'd0;
    sw_data   = 4'h9;
    s0        = strobe_cnt;
    btn_write = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("t1_strobe_k%0d", k), wr_strobe, (k == 6));
      if (k == 6) chk("t1_ptr_before", wr_ptr, 0);
      if (k == 7) begin
        chk("t1_ptr_after", wr_ptr, 1);
        chk("t1_rd_old", rd_data, exp_fill[0]);
      end
      if (k == 8) chk("t1_rd_new", rd_data, 4'h9);
      if (k == 9) btn_write = 1'b0;
    end
    repeat (8) tick();
    chk("t1_one_strobe", strobe_cnt - s0, 1);
    exp_mem[0] = 4'h9;
    exp_ptr    = 3'd1;

    // Bouncing 1-0-1 then stable: exactly one write, strobe 8 edges after the first bounce
    sw_data   = 4'h5;
    s0        = strobe_cnt;
    btn_write = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("t2_strobe_k%0d", k), wr_strobe, (k == 8));
      btn_write = ((k + 1) == 1) ? 1'b0 : ((k + 1) < 12);
    end
    repeat (6) tick();
    chk("t2_one_strobe", strobe_cnt - s0, 1);
    chk("t2_ptr", wr_ptr, 2);
    exp_mem[1] = 4'h5;
    exp_ptr    = 3'd2;

    // Nine writes from a clean reset: fills, wraps, overwrites the oldest entry
    do_reset();
    for (int i = 0; i < 9; i++) begin
      wtbl[i].val  = 4'(i + 1);
      wtbl[i].ptr  = 3'((i + 1) % 8);
      wtbl[i].full = (i >= 7);
    end
    for (int i = 0; i < 9; i++) begin
      do_write(wtbl[i].val);
      chk($sformatf("t3_ptr_w%0d", i + 1), wr_ptr, wtbl[i].ptr);
      chk($sformatf("t3_full_w%0d", i + 1), msg_full, wtbl[i].full);
    end
    read_all("wrap");

    // Clear and write pressed together: clear wins, 8-cycle sweep, no strobe
    s0        = strobe_cnt;
    sw_data   = 4'hF;
    btn_clear = 1'b1;
    btn_write = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("t4_busy_k%0d", k), busy, (k >= 6 && k <= 13));
      chk($sformatf("t4_ptr_k%0d", k), wr_ptr, (k >= 14) ? 0 : 1);
      chk($sformatf("t4_full_k%0d", k), msg_full, (k < 14));
      if (k == 9) begin
        btn_clear = 1'b0;
        btn_write = 1'b0;
      end
    end
    repeat (8) tick();
    chk("t4_no_strobe", strobe_cnt - s0, 0);
    model_fill();
    read_all("clr");

    // Reset during a clear sweep aborts it and reloads the whole memory
    do_write(4'h7);
    do_write(4'h6);
    do_write(4'h5);
    do_write(4'h4);
    do_write(4'h3);
    chk("t5_ptr", wr_ptr, 5);
    rd_addr   = 3'd3;
    btn_clear = 1'b1;
    w = 0;
    while (!busy && w < 20) begin
      tick();
      w++;
    end
    chk("t5_busy_seen", busy, 1);
    repeat (2) tick();
    chk("t5_partial_rd", rd_data, 4'h4);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rd_data", rd_data, 0);
    chk("t5_busy", busy, 0);
    chk("t5_strobe", wr_strobe, 0);
    chk("t5_full", msg_full, 0);
    chk("t5_wr_ptr", wr_ptr, 0);
    chk("t5_state", dbg_state, 0);
    btn_clear = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    model_fill();
    read_all("abort");
    do_write(4'hE);
    chk("t5_ptr_after", wr_ptr, 1);
    rd_addr = 3'd0;
    tick();
    chk("t5_rd_addr0", rd_data, 4'hE);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
